// File: rtl/sagu_missq.sv
// Store-AGU miss replay queue: parks DTLB-missed stores until a matching refill
// or a timeout, then replays them to the AGU ahead of new scheduler issue.
module sagu_missq #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int PAGE_SHIFT = 13,
    parameter int OP_WIDTH   = 13,
    parameter int REG_WIDTH  = 9,
    parameter int TIMEOUT    = 63
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_en,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [OP_WIDTH-1:0]          in_op,
    input  logic [REG_WIDTH-1:0]         in_regno,
    input  logic [8:0]                   in_LSQ,
    input  logic [9:0]                   in_II,
    input  logic [7:0]                   in_WQ,
    input  logic                         in_thread,
    input  logic                         miss_en,
    input  logic [ADDR_WIDTH-1:0]        miss_addr,
    input  logic [OP_WIDTH-1:0]          miss_op,
    input  logic [REG_WIDTH-1:0]         miss_regno,
    input  logic [8:0]                   miss_LSQ,
    input  logic [9:0]                   miss_II,
    input  logic [7:0]                   miss_WQ,
    input  logic                         miss_thread,
    input  logic                         fill_en,
    input  logic [ADDR_WIDTH-PAGE_SHIFT-1:0] fill_page,
    input  logic                         except,
    input  logic                         except_thread,
    output logic                         out_en,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic [OP_WIDTH-1:0]          out_op,
    output logic [REG_WIDTH-1:0]         out_regno,
    output logic [8:0]                   out_LSQ,
    output logic [9:0]                   out_II,
    output logic [7:0]                   out_WQ,
    output logic                         out_thread,
    output logic                         out_replay,
    output logic                         doStall,
    output logic                         full,
    output logic                         ovf_err
);

    localparam int PW = ADDR_WIDTH - PAGE_SHIFT;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [OP_WIDTH-1:0]   op;
        logic [REG_WIDTH-1:0]  regno;
        logic [8:0]            lsq;
        logic [9:0]            ii;
        logic [7:0]            wq;
        logic                  thread;
    } op_t;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e      state_q [DEPTH];
    state_e      state_d [DEPTH];
    logic [7:0]  cnt_q   [DEPTH];
    logic [7:0]  cnt_d   [DEPTH];
    op_t         ent_q   [DEPTH];
    op_t         ent_d   [DEPTH];

    op_t         out_q, out_d;
    logic        out_en_q, out_en_d;
    logic        out_replay_q, out_replay_d;
    logic        ovf_q, ovf_d;

    op_t         in_s, miss_s;
    logic        any_ready, any_free;
    logic [IW-1:0] rsel, asel;
    logic [CW-1:0] free_cnt;
    logic [PW-1:0] miss_page;
    logic        flush_miss, flush_rep, flush_in;

    assign in_s   = '{addr: in_addr, op: in_op, regno: in_regno, lsq: in_LSQ,
                      ii: in_II, wq: in_WQ, thread: in_thread};
    assign miss_s = '{addr: miss_addr, op: miss_op, regno: miss_regno, lsq: miss_LSQ,
                      ii: miss_II, wq: miss_WQ, thread: miss_thread};
    assign miss_page = miss_addr[ADDR_WIDTH-1:PAGE_SHIFT];

    // Lowest-index READY entry replays first; lowest-index FREE entry is allocated.
    always_comb begin
        any_ready = 1'b0;
        any_free  = 1'b0;
        rsel      = '0;
        asel      = '0;
        free_cnt  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == ST_READY) begin
                any_ready = 1'b1;
                rsel      = IW'(i);
            end
            if (state_q[i] == ST_FREE) begin
                any_free = 1'b1;
                asel     = IW'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] == ST_FREE) free_cnt = free_cnt + CW'(1);
        end
    end

    // Two free entries are held back for stores already in flight in the AGU.
    assign doStall = any_ready | (free_cnt < CW'(2));
    assign full    = (free_cnt == '0);

    assign flush_miss = except && (miss_thread == except_thread);
    assign flush_rep  = except && (ent_q[rsel].thread == except_thread);
    assign flush_in   = except && (in_thread == except_thread);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ent_d        = ent_q;
        out_d        = out_q;
        out_en_d     = 1'b0;
        out_replay_d = 1'b0;
        ovf_d        = ovf_q;

        if (any_ready) begin
            if (!flush_rep) begin
                out_d        = ent_q[rsel];
                out_en_d     = 1'b1;
                out_replay_d = 1'b1;
            end
            if (in_en) ovf_d = 1'b1;
        end else if (in_en && !flush_in) begin
            out_d    = in_s;
            out_en_d = 1'b1;
        end

        for (int i = 0; i < DEPTH; i++) begin
            case (state_q[i])
                ST_WAIT: begin
                    if (cnt_q[i] != 8'hFF) cnt_d[i] = cnt_q[i] + 8'd1;
                    if ((fill_en && (ent_q[i].addr[ADDR_WIDTH-1:PAGE_SHIFT] == fill_page)) ||
                        (cnt_q[i] >= TO_M1))
                        state_d[i] = ST_READY;
                end
                ST_READY: begin
                    if (rsel == IW'(i)) state_d[i] = ST_FREE;
                end
                default: ;
            endcase
            // Flush overrides any READY transition made above.
            if (except && (state_q[i] != ST_FREE) && (ent_q[i].thread == except_thread))
                state_d[i] = ST_FREE;
        end

        if (miss_en && !flush_miss) begin
            if (any_free) begin
                state_d[asel] = (fill_en && (fill_page == miss_page)) ? ST_READY : ST_WAIT;
                cnt_d[asel]   = 8'd0;
                ent_d[asel]   = miss_s;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
                cnt_q[i]   <= 8'd0;
            end
            out_q        <= '0;
            out_en_q     <= 1'b0;
            out_replay_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            out_q        <= out_d;
            out_en_q     <= out_en_d;
            out_replay_q <= out_replay_d;
            ovf_q        <= ovf_d;
        end
    end

    // Entry payloads are qualified by state, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end

    assign out_en     = out_en_q;
    assign out_replay = out_replay_q;
    assign ovf_err    = ovf_q;
    assign out_addr   = out_q.addr;
    assign out_op     = out_q.op;
    assign out_regno  = out_q.regno;
    assign out_LSQ    = out_q.lsq;
    assign out_II     = out_q.ii;
    assign out_WQ     = out_q.wq;
    assign out_thread = out_q.thread;

endmodule
